// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the PISO chain scan controller: state encoding and counter sizing.
package piso_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] SHIFT_LO = 3'd2;
  localparam logic [STATE_W-1:0] SHIFT_HI = 3'd3;
  localparam logic [STATE_W-1:0] DONE     = 3'd4;

  // Width needed to hold the larger of two phase lengths without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_tick_gen.sv
// Reloadable down-counter; phase_end_c marks the last cycle of an N-cycle phase.
module piso_tick_gen #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_end_c
);

  logic [CNT_W-1:0] cnt;

  // Loaded with N on phase entry, so the phase's final cycle sees cnt == 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign phase_end_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/piso_scan_ctrl.sv
// Sequencer for a 165-style PISO chain: loads, clocks out CHAIN_WIDTH bits LSB first,
// and presents the assembled word on a valid/ready handshake.
module piso_scan_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_WIDTH = 8,
  parameter int unsigned DIV         = 4,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   q,
  output logic                   shld,
  output logic                   sclk,
  output logic                   busy,
  output logic [CHAIN_WIDTH-1:0] data,
  output logic                   valid,
  input  logic                   ready
);

  localparam int unsigned BIT_W = $clog2(CHAIN_WIDTH + 1);
  localparam int unsigned CNT_W = cnt_width(DIV, LOAD_CYCLES);

  logic [STATE_W-1:0]     state, state_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [CHAIN_WIDTH-1:0] cap, cap_nxt, data_nxt;
  logic                   shld_nxt, sclk_nxt, busy_nxt, valid_nxt;
  logic                   tick_load_c, phase_end_c;
  logic [CNT_W-1:0]       tick_val_c;

  piso_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .load        (tick_load_c),
    .load_val    (tick_val_c),
    .phase_end_c (phase_end_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cap     <= '0;
      data    <= '0;
      shld    <= 1'b1;
      sclk    <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cap     <= cap_nxt;
      data    <= data_nxt;
      shld    <= shld_nxt;
      sclk    <= sclk_nxt;
      busy    <= busy_nxt;
      valid   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cap_nxt     = cap;
    data_nxt    = data;
    unique case (state)
      IDLE: begin
        if (start || cont) begin
          state_nxt   = LOAD;
          bit_cnt_nxt = '0;
          cap_nxt     = '0;
        end
      end
      LOAD: begin
        if (phase_end_c) state_nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        // Sample just before the rising sclk edge that advances the chain.
        if (phase_end_c) begin
          cap_nxt   = cap | (CHAIN_WIDTH'(q) << bit_cnt);
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (phase_end_c) begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt_nxt == BIT_W'(CHAIN_WIDTH)) begin
            state_nxt = DONE;
            data_nxt  = cap;
          end else begin
            state_nxt = SHIFT_LO;
          end
        end
      end
      DONE: begin
        if (valid && ready) begin
          if (cont) begin
            state_nxt   = LOAD;
            bit_cnt_nxt = '0;
            cap_nxt     = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they never glitch.
    shld_nxt    = (state_nxt != LOAD);
    sclk_nxt    = (state_nxt == SHIFT_HI);
    busy_nxt    = (state_nxt != IDLE);
    valid_nxt   = (state_nxt == DONE);
    tick_load_c = (state_nxt != state);
    tick_val_c  = (state_nxt == LOAD) ? CNT_W'(LOAD_CYCLES) : CNT_W'(DIV);
  end

endmodule
